// File: rtl/mac_sequencer.sv
// Sequences one signed dot product through an external DSP multiplier.
// The result is accumulated with saturation and held on a valid/ready output.
//
// state    | meaning
// IDLE     | waiting for start; len and bias captured on acceptance
// FETCH    | one buffer read per cycle, addr = 0..len-1
// DRAIN    | waits for all issued products to retire into the accumulator
// OUTPUT   | acc_out_o held with out_valid_o until out_ready_i
module mac_sequencer #(
  parameter int ADDR_W   = 10,
  parameter int CNT_W    = 11,
  parameter int MULT_LAT = 1,
  parameter int ACC_W    = 24
) (
  input  logic              clock_i,
  input  logic              aclr_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic [7:0]        bias_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              rd_en_o,
  input  logic [7:0]        wdata_i,
  input  logic [7:0]        xdata_i,
  output logic [7:0]        mult_dataa_o,
  output logic [7:0]        mult_datab_o,
  output logic [7:0]        mult_sumin_o,
  output logic              mult_clken_o,
  input  logic [15:0]       mult_result_i,
  output logic [ACC_W-1:0]  acc_out_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DRAIN  = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    rem_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          bias_q;
  logic                first_q;
  logic                op0_q;
  logic [MULT_LAT:0]   vld_q;
  logic [ACC_W-1:0]    acc_q;
  logic                sat_q;

  logic                accept;
  logic                fetch;
  logic [ACC_W:0]      sum_w;
  logic                ovf;

  assign accept = (state_q == S_IDLE) && start_i;
  assign fetch  = (state_q == S_FETCH);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = (len_i == '0) ? S_OUTPUT : S_FETCH;
      S_FETCH:  if (rem_q == CNT_W'(1)) state_d = S_DRAIN;
      S_DRAIN:  if (vld_q == '0) state_d = S_OUTPUT;
      S_OUTPUT: if (out_ready_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // One extra guard bit catches signed overflow of the running sum.
  always_comb begin
    sum_w = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-15){mult_result_i[15]}}, mult_result_i};
    ovf   = sum_w[ACC_W] ^ sum_w[ACC_W-1];
  end

  always_ff @(posedge clock_i) begin
    if (aclr_i) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
      bias_q  <= '0;
      first_q <= 1'b0;
      op0_q   <= 1'b0;
      vld_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= {vld_q[MULT_LAT-1:0], fetch};
      op0_q   <= fetch && first_q;
      if (accept) begin
        rem_q   <= len_i;
        addr_q  <= '0;
        bias_q  <= bias_i;
        first_q <= 1'b1;
        sat_q   <= 1'b0;
        acc_q   <= (len_i == '0) ? {{(ACC_W-8){bias_i[7]}}, bias_i} : '0;
      end
      if (fetch) begin
        rem_q   <= rem_q - CNT_W'(1);
        addr_q  <= addr_q + ADDR_W'(1);
        first_q <= 1'b0;
      end
      // Once saturated the accumulator is frozen for the rest of the job.
      if (vld_q[MULT_LAT] && !sat_q) begin
        if (ovf) begin
          acc_q <= sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
          sat_q <= 1'b1;
        end else begin
          acc_q <= sum_w[ACC_W-1:0];
        end
      end
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign rd_en_o      = fetch;
  assign addr_o       = addr_q;
  assign mult_dataa_o = wdata_i;
  assign mult_datab_o = xdata_i;
  assign mult_sumin_o = op0_q ? bias_q : 8'd0;
  assign mult_clken_o = fetch || (state_q == S_DRAIN);
  assign acc_out_o    = acc_q;
  assign out_valid_o  = (state_q == S_OUTPUT);

endmodule
